// File: rtl/ml_smc_cram_seq_if.sv
// Command handshake bundle between the SMC control logic and the CRAM sequencer.
interface ml_smc_cram_seq_if;
  logic cmd_valid;
  logic cmd_rd;
  logic cmd_ready;
  logic abort;
  logic busy;
  logic done;
  logic err;

  modport master (
    output cmd_valid, cmd_rd, abort,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_rd, abort,
    output cmd_ready, busy, done, err
  );
endinterface

// File: rtl/ml_smc_cram_seq.sv
// CRAM access sequencer: expands write/read commands into smc_* phase strobes.
// Read path built only when ML_SMC_CRAM_READ_EN is defined.
module ml_smc_cram_seq #(
  parameter int PREC_CYC = 2,
  parameter int WL_CYC   = 4,
  parameter int CNT_W    = 8
) (
  input  logic smc_clk,
  input  logic por,
  ml_smc_cram_seq_if.slave cmd,
  output logic smc_write,
  output logic smc_wcram_rst,
  output logic smc_wset_prec,
  output logic smc_wset_precgnd,
  output logic smc_wwlwrt_en,
  output logic smc_wwlwrt_dis,
  output logic smc_read,
  output logic smc_rrst_pullwlen,
  output logic smc_rprec,
  output logic smc_rpull_b,
  output logic smc_rwl_en,
  output logic smc_seq_rst
);

  localparam int PREC_L = (PREC_CYC == 0) ? 1 : PREC_CYC;
  localparam int WL_L   = (WL_CYC == 0) ? 1 : WL_CYC;
  localparam logic [CNT_W-1:0] PREC_LD = CNT_W'(PREC_L - 1);
  localparam logic [CNT_W-1:0] WL_LD   = CNT_W'(WL_L - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [3:0] {
    INIT, IDLE,
    W_RST, W_PREC, W_PGND, W_WLEN, W_WLDIS,
`ifdef ML_SMC_CRAM_READ_EN
    R_RST, R_PREC, R_PULL, R_WL,
`endif
    FIN
  } state_t;

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             err_n;
  logic             in_seq;
  logic             nxt_w;

  always_comb begin
    nxt    = state;
    cnt_n  = cnt;
    err_n  = 1'b0;
    in_seq = 1'b0;
    unique case (state)
      INIT: begin
        if (cnt == '0) nxt = IDLE;
        else cnt_n = cnt - ONE;
      end
      IDLE: begin
        if (cmd.cmd_valid) begin
`ifdef ML_SMC_CRAM_READ_EN
          nxt = cmd.cmd_rd ? R_RST : W_RST;
`else
          if (cmd.cmd_rd) begin
            nxt   = FIN;
            err_n = 1'b1;
          end else begin
            nxt = W_RST;
          end
`endif
        end
      end
      W_RST: begin
        in_seq = 1'b1;
        nxt    = W_PREC;
        cnt_n  = PREC_LD;
      end
      W_PREC: begin
        in_seq = 1'b1;
        if (cnt == '0) nxt = W_PGND;
        else cnt_n = cnt - ONE;
      end
      W_PGND: begin
        in_seq = 1'b1;
        nxt    = W_WLEN;
        cnt_n  = WL_LD;
      end
      W_WLEN: begin
        in_seq = 1'b1;
        if (cnt == '0) nxt = W_WLDIS;
        else cnt_n = cnt - ONE;
      end
      W_WLDIS: begin
        in_seq = 1'b1;
        nxt    = FIN;
      end
`ifdef ML_SMC_CRAM_READ_EN
      R_RST: begin
        in_seq = 1'b1;
        nxt    = R_PREC;
        cnt_n  = PREC_LD;
      end
      R_PREC: begin
        in_seq = 1'b1;
        if (cnt == '0) nxt = R_PULL;
        else cnt_n = cnt - ONE;
      end
      R_PULL: begin
        in_seq = 1'b1;
        nxt    = R_WL;
        cnt_n  = WL_LD;
      end
      R_WL: begin
        in_seq = 1'b1;
        if (cnt == '0) nxt = FIN;
        else cnt_n = cnt - ONE;
      end
`endif
      FIN: nxt = IDLE;
      default: begin
        nxt   = INIT;
        cnt_n = ONE;
      end
    endcase
    // abort restarts the two-cycle INIT hold
    if (in_seq && cmd.abort) begin
      nxt   = INIT;
      cnt_n = ONE;
      err_n = 1'b1;
    end
  end

  assign nxt_w = nxt inside {W_RST, W_PREC, W_PGND, W_WLEN, W_WLDIS};

  always_ff @(posedge smc_clk or posedge por) begin
    if (por) begin
      state            <= INIT;
      cnt              <= ONE;
      cmd.cmd_ready    <= 1'b0;
      cmd.busy         <= 1'b1;
      cmd.done         <= 1'b0;
      cmd.err          <= 1'b0;
      smc_seq_rst      <= 1'b1;
      smc_write        <= 1'b0;
      smc_wcram_rst    <= 1'b0;
      smc_wset_prec    <= 1'b0;
      smc_wset_precgnd <= 1'b0;
      smc_wwlwrt_en    <= 1'b0;
      smc_wwlwrt_dis   <= 1'b0;
    end else begin
      state            <= nxt;
      cnt              <= cnt_n;
      cmd.cmd_ready    <= nxt == IDLE;
      cmd.busy         <= nxt != IDLE;
      cmd.done         <= (nxt == FIN) && !err_n;
      cmd.err          <= err_n;
      smc_seq_rst      <= nxt == INIT;
      smc_write        <= nxt_w;
      smc_wcram_rst    <= nxt == W_RST;
      smc_wset_prec    <= nxt == W_PREC;
      smc_wset_precgnd <= nxt == W_PGND;
      smc_wwlwrt_en    <= nxt == W_WLEN;
      smc_wwlwrt_dis   <= nxt == W_WLDIS;
    end
  end

`ifdef ML_SMC_CRAM_READ_EN
  always_ff @(posedge smc_clk or posedge por) begin
    if (por) begin
      smc_read          <= 1'b0;
      smc_rrst_pullwlen <= 1'b0;
      smc_rprec         <= 1'b0;
      smc_rpull_b       <= 1'b1;
      smc_rwl_en        <= 1'b0;
    end else begin
      smc_read          <= nxt inside {R_RST, R_PREC, R_PULL, R_WL};
      smc_rrst_pullwlen <= nxt == R_RST;
      smc_rprec         <= nxt == R_PREC;
      smc_rpull_b       <= nxt != R_PULL;
      smc_rwl_en        <= nxt == R_WL;
    end
  end
`else
  assign smc_read          = 1'b0;
  assign smc_rrst_pullwlen = 1'b0;
  assign smc_rprec         = 1'b0;
  assign smc_rpull_b       = 1'b1;
  assign smc_rwl_en        = 1'b0;
`endif

endmodule

// File: tb/tb_ml_smc_cram_seq.sv
// Scoreboard bench for ml_smc_cram_seq: default instance plus a
// zero-length-phase instance, compared cycle by cycle on the falling edge.
module tb_ml_smc_cram_seq;

  localparam logic [15:0] RDY   = 16'h8000;
  localparam logic [15:0] BUSY  = 16'h4000;
  localparam logic [15:0] DONE  = 16'h2000;
  localparam logic [15:0] ERR   = 16'h1000;
  localparam logic [15:0] SRST  = 16'h0800;
  localparam logic [15:0] WR    = 16'h0400;
  localparam logic [15:0] WRST  = 16'h0200;
  localparam logic [15:0] WPREC = 16'h0100;
  localparam logic [15:0] WPGND = 16'h0080;
  localparam logic [15:0] WWLEN = 16'h0040;
  localparam logic [15:0] WWLD  = 16'h0020;
  localparam logic [15:0] RD    = 16'h0010;
  localparam logic [15:0] RRST  = 16'h0008;
  localparam logic [15:0] RPREC = 16'h0004;
  localparam logic [15:0] PULLB = 16'h0002;
  localparam logic [15:0] RWL   = 16'h0001;

  localparam logic [15:0] V_IDLE = RDY | PULLB;
  localparam logic [15:0] V_INIT = BUSY | SRST | PULLB;
  localparam logic [15:0] V_FIN  = BUSY | DONE | PULLB;

  logic        clk = 1'b0;
  logic        por;
  logic [11:0] st0, st1;
  int          total = 0;
  int          bad = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  ml_smc_cram_seq_if i0 ();
  ml_smc_cram_seq_if i1 ();

  always #5 clk = ~clk;

  ml_smc_cram_seq u0 (
    .smc_clk(clk), .por(por), .cmd(i0.slave),
    .smc_write(st0[10]), .smc_wcram_rst(st0[9]),
    .smc_wset_prec(st0[8]), .smc_wset_precgnd(st0[7]),
    .smc_wwlwrt_en(st0[6]), .smc_wwlwrt_dis(st0[5]),
    .smc_read(st0[4]), .smc_rrst_pullwlen(st0[3]),
    .smc_rprec(st0[2]), .smc_rpull_b(st0[1]),
    .smc_rwl_en(st0[0]), .smc_seq_rst(st0[11])
  );

  ml_smc_cram_seq #(.PREC_CYC(0), .WL_CYC(0)) u1 (
    .smc_clk(clk), .por(por), .cmd(i1.slave),
    .smc_write(st1[10]), .smc_wcram_rst(st1[9]),
    .smc_wset_prec(st1[8]), .smc_wset_precgnd(st1[7]),
    .smc_wwlwrt_en(st1[6]), .smc_wwlwrt_dis(st1[5]),
    .smc_read(st1[4]), .smc_rrst_pullwlen(st1[3]),
    .smc_rprec(st1[2]), .smc_rpull_b(st1[1]),
    .smc_rwl_en(st1[0]), .smc_seq_rst(st1[11])
  );

  function automatic logic [15:0] obs0();
    return {i0.cmd_ready, i0.busy, i0.done, i0.err, st0};
  endfunction

  function automatic logic [15:0] obs1();
    return {i1.cmd_ready, i1.busy, i1.done, i1.err, st1};
  endfunction

  task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, o, e);
    end
  endtask

  task automatic pb(int s, logic [15:0] v, int n);
    repeat (n) begin
      if (s == 0) q0.push_back(v);
      else q1.push_back(v);
    end
  endtask

  task automatic wtrace(int s, int p, int w);
    pb(s, BUSY | WR | WRST | PULLB, 1);
    pb(s, BUSY | WR | WPREC | PULLB, (p == 0) ? 1 : p);
    pb(s, BUSY | WR | WPGND | PULLB, 1);
    pb(s, BUSY | WR | WWLEN | PULLB, (w == 0) ? 1 : w);
    pb(s, BUSY | WR | WWLD | PULLB, 1);
    pb(s, V_FIN, 1);
    pb(s, V_IDLE, 1);
  endtask

  task automatic rtrace(int s, int p, int w);
`ifdef ML_SMC_CRAM_READ_EN
    pb(s, BUSY | RD | RRST | PULLB, 1);
    pb(s, BUSY | RD | RPREC | PULLB, (p == 0) ? 1 : p);
    pb(s, BUSY | RD, 1);
    pb(s, BUSY | RD | RWL | PULLB, (w == 0) ? 1 : w);
    pb(s, V_FIN, 1);
`else
    pb(s, BUSY | ERR | PULLB, 1);
`endif
    pb(s, V_IDLE, 1);
  endtask

  task automatic drain(string tag);
    int c = 0;
    while (q0.size() > 0 || q1.size() > 0) begin
      @(negedge clk);
      c++;
      if (q0.size() > 0)
        chk($sformatf("%s u0 c%0d", tag, c), obs0(), q0.pop_front());
      if (q1.size() > 0)
        chk($sformatf("%s u1 c%0d", tag, c), obs1(), q1.pop_front());
    end
  endtask

  task automatic accept_edge();
    @(posedge clk);
    #1;
    i0.cmd_valid = 1'b0;
    i1.cmd_valid = 1'b0;
    i0.abort = 1'b0;
    i1.abort = 1'b0;
  endtask

  initial begin
    por = 1'b1;
    i0.cmd_valid = 1'b0; i0.cmd_rd = 1'b0; i0.abort = 1'b0;
    i1.cmd_valid = 1'b0; i1.cmd_rd = 1'b0; i1.abort = 1'b0;

    // reset hold and release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("por u0", obs0(), V_INIT);
    chk("por u1", obs1(), V_INIT);
    por = 1'b0;
    pb(0, V_INIT, 1); pb(0, V_IDLE, 1);
    pb(1, V_INIT, 1); pb(1, V_IDLE, 1);
    drain("rel");

    // writes: default phases and zero-length phases
    i0.cmd_valid = 1'b1; i0.cmd_rd = 1'b0;
    i1.cmd_valid = 1'b1; i1.cmd_rd = 1'b0;
    accept_edge();
    wtrace(0, 2, 4);
    wtrace(1, 0, 0);
    drain("wr");

    // read on u0; u1 takes a write with abort raised in IDLE
    i0.cmd_valid = 1'b1; i0.cmd_rd = 1'b1;
    i1.cmd_valid = 1'b1; i1.cmd_rd = 1'b0; i1.abort = 1'b1;
    accept_edge();
    rtrace(0, 2, 4);
    wtrace(1, 0, 0);
    drain("rd");

    // abort during the wordline phase of a write
    i0.cmd_valid = 1'b1; i0.cmd_rd = 1'b0;
    accept_edge();
    pb(0, BUSY | WR | WRST | PULLB, 1);
    pb(0, BUSY | WR | WPREC | PULLB, 2);
    pb(0, BUSY | WR | WPGND | PULLB, 1);
    pb(0, BUSY | WR | WWLEN | PULLB, 1);
    drain("ab0");
    i0.abort = 1'b1;
    accept_edge();
    pb(0, V_INIT | ERR, 1);
    pb(0, V_INIT, 1);
    pb(0, V_IDLE, 1);
    drain("ab1");

    // write after abort, request held high while busy
    i0.cmd_valid = 1'b1; i0.cmd_rd = 1'b0;
    @(posedge clk);
    #1;
    wtrace(0, 2, 4);
    repeat (4) begin
      @(negedge clk);
      chk("hold u0", obs0(), q0.pop_front());
    end
    i0.cmd_valid = 1'b0;
    drain("hold");

    // abort in IDLE is ignored
    i0.abort = 1'b1;
    pb(0, V_IDLE, 3);
    drain("idab");
    i0.abort = 1'b0;

    // asynchronous por mid-sequence
    i0.cmd_valid = 1'b1; i0.cmd_rd = 1'b0;
    accept_edge();
    pb(0, BUSY | WR | WRST | PULLB, 1);
    pb(0, BUSY | WR | WPREC | PULLB, 2);
    drain("pm0");
    #2;
    por = 1'b1;
    #1;
    chk("apor u0", obs0(), V_INIT);
    chk("apor u1", obs1(), V_INIT);
    @(negedge clk);
    por = 1'b0;
    pb(0, V_INIT, 1); pb(0, V_IDLE, 1);
    pb(1, V_INIT, 1); pb(1, V_IDLE, 1);
    drain("pm1");

    chk("q0 empty", 16'(q0.size()), 16'h0);
    chk("q1 empty", 16'(q1.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
